wg_nlfsr_core: RTL and testbench

- Nonlinear feedback shift register over GF(2^5); the stage directly upstream of the WGT lookup.
- Drives the 5-bit address of WGT1_5/WGT2_5 and takes the selected LUT bit back.
- Seed path: absorbs seed symbols, mixes with raw TRNG entropy and WGT feedback for a fixed number of init rounds, then emits one post-processed bit per valid/ready handshake.
- Instantiates gamma_mult for the gamma·S[0] feedback term.

---
 rtl/wg_pkg.sv | 30 +++
 rtl/gamma_mult.sv | 18 +
 rtl/wg_nlfsr_core.sv | 150 +++++++++++++++
 tb/tb_wg_nlfsr_core.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wg_pkg.sv
// Shared types and constants for the WG-5 NLFSR datapath.
//   WG_W        : GF(2^5) symbol width
//   gf5_t       : one field element / state cell
//   wg_state_e  : NLFSR controller states
//   TAP_0..4    : state cells XORed into the feedback (S[2],S[3],S[4],S[6],S[7])
//   gf_xtime    : multiply by x modulo x^5 + x^4 + x^3 + x + 1
package wg_pkg;

  localparam int unsigned WG_W = 5;

  typedef logic [WG_W-1:0] gf5_t;

  typedef enum logic [1:0] {IDLE, LOAD, INIT, RUN} wg_state_e;

  localparam int unsigned TAP_0 = 2;
  localparam int unsigned TAP_1 = 3;
  localparam int unsigned TAP_2 = 4;
  localparam int unsigned TAP_3 = 6;
  localparam int unsigned TAP_4 = 7;

  // Low five bits of the field polynomial: x^5 == x^4 + x^3 + x + 1
  localparam gf5_t GF_POLY_LOW = 5'b11011;

  function automatic gf5_t gf_xtime(input gf5_t a);
    gf5_t sh;
    sh = {a[WG_W-2:0], 1'b0};
    return a[WG_W-1] ? (sh ^ GF_POLY_LOW) : sh;
  endfunction

endpackage

// File: rtl/gamma_mult.sv
// Constant multiplier y = gamma * a over GF(2^5), gamma = x^3 + x^2 (5'b01100).
//   a : multiplicand (state cell S[0])
//   y : product
module gamma_mult
  import wg_pkg::*;
(
  input  gf5_t a,
  output gf5_t y
);

  gf5_t a_x2;
  gf5_t a_x3;

  assign a_x2 = gf_xtime(gf_xtime(a));
  assign a_x3 = gf_xtime(a_x2);
  assign y    = a_x3 ^ a_x2;

endmodule

// File: rtl/wg_nlfsr_core.sv
// WG-5 nonlinear feedback shift register core.
//   clk, rst          : clock, asynchronous active-low reset
//   start             : IDLE -> LOAD request
//   reseed            : RUN -> LOAD request (drops any pending output bit)
//   seed_valid/ready  : seed symbol handshake, seed_data is the symbol
//   ent_bit           : raw entropy bit mixed into feedback bit 0 during INIT
//   wgt_addr/wgt_bit  : address to and bit from the external WGT lookup
//   out_valid/ready   : output bit handshake, out_bit is the captured LUT bit
//   busy              : high during LOAD and INIT
module wg_nlfsr_core
  import wg_pkg::*;
#(
  parameter int unsigned STAGES      = 32,
  parameter int unsigned INIT_ROUNDS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            reseed,
  input  logic            seed_valid,
  input  logic [WG_W-1:0] seed_data,
  output logic            seed_ready,
  input  logic            ent_bit,
  output logic [WG_W-1:0] wgt_addr,
  input  logic            wgt_bit,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic            busy
);

  localparam int unsigned SR_W    = STAGES * WG_W;
  localparam int unsigned CNT_MAX = (STAGES > INIT_ROUNDS) ? STAGES : INIT_ROUNDS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(STAGES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_ROUNDS - 1);

  // S[i] lives in sr[i*WG_W +: WG_W]; S[0] is the low symbol.
  logic [SR_W-1:0] sr;
  wg_state_e       state;
  logic [CNT_W-1:0] cnt;

  gf5_t gamma_s0;
  gf5_t fb_run;
  gf5_t shift_in;
  logic shift_en;
  logic seed_fire;
  logic capture;

  gamma_mult u_gamma (
    .a (sr[WG_W-1:0]),
    .y (gamma_s0)
  );

  assign wgt_addr = sr[WG_W-1:0];

  assign fb_run = gamma_s0
                ^ sr[TAP_0*WG_W +: WG_W]
                ^ sr[TAP_1*WG_W +: WG_W]
                ^ sr[TAP_2*WG_W +: WG_W]
                ^ sr[TAP_3*WG_W +: WG_W]
                ^ sr[TAP_4*WG_W +: WG_W];

  assign seed_fire = seed_valid && seed_ready;

  // First RUN cycle is recognised by out_valid still being low; reseed
  // takes priority over a simultaneous handshake.
  assign capture = (state == RUN) && !reseed && (!out_valid || out_ready);

  always_comb begin
    shift_en = 1'b0;
    shift_in = fb_run;
    case (state)
      LOAD: begin
        shift_en = seed_fire;
        shift_in = seed_data;
      end
      INIT: begin
        shift_en = 1'b1;
        shift_in = fb_run ^ {{(WG_W-1){1'b0}}, wgt_bit ^ ent_bit};
      end
      RUN: shift_en = capture;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= {shift_in, sr[SR_W-1:WG_W]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      seed_ready <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            cnt        <= '0;
            seed_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (seed_fire) begin
            if (cnt == LOAD_LAST) begin
              state      <= INIT;
              cnt        <= '0;
              seed_ready <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        INIT: begin
          if (cnt == INIT_LAST) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (reseed) begin
            state      <= LOAD;
            cnt        <= '0;
            seed_ready <= 1'b1;
            busy       <= 1'b1;
            out_valid  <= 1'b0;
          end else if (capture) begin
            out_valid <= 1'b1;
            out_bit   <= wgt_bit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wg_nlfsr_core.sv
module tb_wg_nlfsr_core;
  import wg_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       reseed;
  logic       seed_valid;
  logic [4:0] seed_data;
  logic       seed_ready;
  logic       ent_bit;
  logic [4:0] wgt_addr;
  logic       wgt_bit;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       busy;

  // Bench-side WGT lookup table (entry 0 = 1); wgt_mode=0 ties wgt_bit low.
  logic [31:0] wgt_lut = 32'h6F2AD395;
  logic        wgt_mode;
  assign wgt_bit = wgt_mode ? wgt_lut[wgt_addr] : 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [159:0] mdl;
  logic [4:0]   seed_q [32];

  wg_nlfsr_core #(.STAGES(32), .INIT_ROUNDS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .reseed     (reseed),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .seed_ready (seed_ready),
    .ent_bit    (ent_bit),
    .wgt_addr   (wgt_addr),
    .wgt_bit    (wgt_bit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference gamma multiply: carry-less product by 5'b01100, then long
  // division by x^5 + x^4 + x^3 + x + 1.
  function automatic logic [4:0] ref_gamma(input logic [4:0] a);
    logic [8:0] p;
    p = '0;
    for (int i = 0; i < 5; i++)
      if (a[i]) p = p ^ (9'b000001100 << i);
    for (int i = 8; i >= 5; i--)
      if (p[i]) p = p ^ (9'b000111011 << (i - 5));
    return p[4:0];
  endfunction

  function automatic logic [4:0] ref_fb(input logic [159:0] m, input logic inj);
    return ref_gamma(m[4:0]) ^ m[14:10] ^ m[19:15] ^ m[24:20] ^ m[34:30] ^ m[39:35]
           ^ {4'b0000, inj};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst = 1'b0;
    start = 1'b0; reseed = 1'b0; seed_valid = 1'b0; out_ready = 1'b0;
    tick;
    rst = 1'b1;
    mdl = '0;
    tick;
  endtask

  task automatic do_load(input int stall_at);
    start = 1'b1;
    tick;
    start = 1'b0;
    vec_cnt++;
    if (seed_ready !== 1'b1 || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL load_entry: seed_ready=%b busy=%b, required 1 1", seed_ready, busy);
    end
    for (int i = 0; i < 32; i++) begin
      if (i == stall_at) begin
        seed_valid = 1'b0;
        repeat (3) tick;
        vec_cnt++;
        if (dut.sr !== mdl || dut.state !== LOAD) begin
          err_cnt++;
          $display("FAIL load_stall: sr=%h state=%0d, required sr=%h state=LOAD",
                   dut.sr, dut.state, mdl);
        end
      end
      seed_valid = 1'b1;
      seed_data  = seed_q[i];
      tick;
      mdl = {seed_q[i], mdl[159:5]};
    end
    seed_valid = 1'b0;
  endtask

  task automatic test_reset;
    vec_cnt++;
    if (seed_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_bit !== 1'b0 ||
        wgt_addr !== 5'd0 || dut.state !== IDLE || dut.sr !== 160'd0) begin
      err_cnt++;
      $display("FAIL reset_values: rdy=%b busy=%b ov=%b ob=%b addr=%h state=%0d, required all 0 / IDLE",
               seed_ready, busy, out_valid, out_bit, wgt_addr, dut.state);
    end
  endtask

  task automatic test_seed_order;
    for (int i = 0; i < 32; i++) seed_q[i] = 5'(i);
    do_load(-1);
    vec_cnt++;
    if (seed_ready !== 1'b0 || busy !== 1'b1 || dut.state !== INIT) begin
      err_cnt++;
      $display("FAIL seed_boundary_ctrl: rdy=%b busy=%b state=%0d, required 0 1 INIT",
               seed_ready, busy, dut.state);
    end
    vec_cnt++;
    if (wgt_addr !== 5'd0 || dut.sr[4:0] !== 5'd0 || dut.sr[159:155] !== 5'd31) begin
      err_cnt++;
      $display("FAIL seed_order_ends: addr=%h S0=%h S31=%h, required 00 00 1f",
               wgt_addr, dut.sr[4:0], dut.sr[159:155]);
    end
    vec_cnt++;
    if (dut.sr !== mdl) begin
      err_cnt++;
      $display("FAIL seed_order_all: sr=%h, required %h", dut.sr, mdl);
    end
  endtask

  task automatic test_reset_mid_init;
    #2;
    rst = 1'b0;
    #1;
    test_reset();
    tick;
    #2;
    rst = 1'b1;
    mdl = '0;
    seed_valid = 1'b1;
    seed_data  = 5'h1F;
    repeat (3) tick;
    seed_valid = 1'b0;
    vec_cnt++;
    if (dut.state !== IDLE || dut.sr !== 160'd0 || seed_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_no_shift: state=%0d sr=%h rdy=%b, required IDLE 0 0",
               dut.state, dut.sr, seed_ready);
    end
  endtask

  task automatic run_gamma(input logic [4:0] s0, input logic [4:0] exp31);
    wgt_mode = 1'b0;
    ent_bit  = 1'b0;
    for (int i = 0; i < 32; i++) seed_q[i] = 5'd0;
    seed_q[0] = s0;
    do_load(-1);
    tick;
    vec_cnt++;
    if (dut.state !== RUN || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL gamma_to_run: state=%0d ov=%b, required RUN 0", dut.state, out_valid);
    end
    vec_cnt++;
    if (dut.sr[159:155] !== exp31 || dut.sr[154:0] !== 155'd0) begin
      err_cnt++;
      $display("FAIL gamma_fb_%b: S31=%b low=%h, required S31=%b low=0",
               s0, dut.sr[159:155], dut.sr[154:0], exp31);
    end
    reset_dut();
  endtask

  task automatic run_inject(input logic ent, input logic [4:0] exp31);
    wgt_mode = 1'b1;
    ent_bit  = ent;
    for (int i = 0; i < 32; i++) seed_q[i] = 5'd0;
    do_load(-1);
    tick;
    vec_cnt++;
    if (dut.sr[159:155] !== exp31) begin
      err_cnt++;
      $display("FAIL inject_ent%b: S31=%b, required %b", ent, dut.sr[159:155], exp31);
    end
    ent_bit = 1'b0;
    reset_dut();
  endtask

  task automatic test_backpressure;
    logic exp_bit;
    wgt_mode = 1'b1;
    ent_bit  = 1'b1;
    for (int i = 0; i < 32; i++) seed_q[i] = 5'(i * 7 + 3);
    do_load(10);
    mdl = {ref_fb(mdl, wgt_lut[mdl[4:0]] ^ 1'b1), mdl[159:5]};
    tick;
    ent_bit = 1'b0;
    vec_cnt++;
    if (dut.sr !== mdl || dut.state !== RUN || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_after_init: sr=%h state=%0d ov=%b, required sr=%h RUN 0",
               dut.sr, dut.state, out_valid, mdl);
    end
    // First RUN cycle captures regardless of out_ready.
    out_ready = 1'b0;
    exp_bit = wgt_lut[mdl[4:0]];
    mdl = {ref_fb(mdl, 1'b0), mdl[159:5]};
    tick;
    vec_cnt++;
    if (out_valid !== 1'b1 || out_bit !== exp_bit || dut.sr !== mdl) begin
      err_cnt++;
      $display("FAIL bp_first_capture: ov=%b ob=%b sr=%h, required 1 %b %h",
               out_valid, out_bit, dut.sr, exp_bit, mdl);
    end
    for (int c = 0; c < 10; c++) begin
      tick;
      vec_cnt++;
      if (out_valid !== 1'b1 || out_bit !== exp_bit || wgt_addr !== mdl[4:0] || dut.sr !== mdl) begin
        err_cnt++;
        $display("FAIL bp_hold_%0d: ov=%b ob=%b addr=%h, required 1 %b %h",
                 c, out_valid, out_bit, wgt_addr, exp_bit, mdl[4:0]);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_bit = wgt_lut[mdl[4:0]];
      mdl = {ref_fb(mdl, 1'b0), mdl[159:5]};
      tick;
      vec_cnt++;
      if (out_bit !== exp_bit || dut.sr !== mdl || out_valid !== 1'b1) begin
        err_cnt++;
        $display("FAIL bp_stream_%0d: ob=%b ov=%b sr=%h, required %b 1 %h",
                 c, out_bit, out_valid, dut.sr, exp_bit, mdl);
      end
    end
    out_ready = 1'b0;
    tick;
    vec_cnt++;
    if (dut.sr !== mdl || out_bit !== exp_bit) begin
      err_cnt++;
      $display("FAIL bp_stop: sr=%h ob=%b, required %h %b", dut.sr, out_bit, mdl, exp_bit);
    end
  endtask

  task automatic test_reseed;
    reseed    = 1'b1;
    out_ready = 1'b1;
    tick;
    reseed    = 1'b0;
    out_ready = 1'b0;
    vec_cnt++;
    if (dut.state !== LOAD || out_valid !== 1'b0 || seed_ready !== 1'b1 || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL reseed_ctrl: state=%0d ov=%b rdy=%b busy=%b, required LOAD 0 1 1",
               dut.state, out_valid, seed_ready, busy);
    end
    vec_cnt++;
    if (dut.sr !== mdl) begin
      err_cnt++;
      $display("FAIL reseed_no_shift: sr=%h, required %h", dut.sr, mdl);
    end
    seed_valid = 1'b1;
    seed_data  = 5'h15;
    tick;
    seed_valid = 1'b0;
    mdl = {5'h15, mdl[159:5]};
    vec_cnt++;
    if (dut.sr !== mdl || dut.state !== LOAD) begin
      err_cnt++;
      $display("FAIL reseed_shift_in: sr=%h state=%0d, required %h LOAD", dut.sr, dut.state, mdl);
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0; reseed = 1'b0; seed_valid = 1'b0; seed_data = '0;
    ent_bit = 1'b0; out_ready = 1'b0; wgt_mode = 1'b0;
    mdl = '0;
    repeat (2) tick;
    test_reset();
    rst = 1'b1;
    tick;
    test_seed_order();
    test_reset_mid_init();
    run_gamma(5'b00001, 5'b01100);
    run_gamma(5'b10101, 5'b10000);
    run_inject(1'b0, 5'b00001);
    run_inject(1'b1, 5'b00000);
    test_backpressure();
    test_reseed();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
